// File: rtl/pattern_machine_pkg.sv
// Shared defaults and mode encodings for the serial pattern matcher.
package pattern_machine_pkg;

    localparam int unsigned W_DEFAULT  = 4;
    localparam int unsigned CW_DEFAULT = 8;

    localparam logic MODE_OVERLAP    = 1'b0;
    localparam logic MODE_NONOVERLAP = 1'b1;

endpackage

// File: rtl/dff_n.sv
// Width-parameterised enabled D register with asynchronous active-low reset to zero.
module dff_n #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pattern_machine.sv
// Serial bit-pattern detector: shifts sampled bits into a history window and
// pulses F when the last W bits equal the loaded pattern; counts matches.
module pattern_machine
    import pattern_machine_pkg::*;
#(
    parameter int unsigned W  = W_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT,
    localparam int unsigned SW = $clog2(W + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          x,
    input  logic          x_valid,
    input  logic          mode,
    input  logic          load,
    input  logic [W-1:0]  pattern,
    output logic          F,
    output logic [SW-1:0] S,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    logic [W-1:0]  pat_q,   hist_d,  hist_q;
    logic [SW-1:0] fill_d,  fill_q;
    logic [CW-1:0] count_d, count_q;
    logic          f_d;

    logic [W-1:0]  hist_shift;
    logic [SW-1:0] fill_inc;
    logic          match;

    // Candidate next window, fill level and match for a sampled bit.
    always_comb begin
        hist_shift = {hist_q[W-2:0], x};
        fill_inc   = (fill_q == SW'(W)) ? fill_q : fill_q + SW'(1);
        match      = !load && x_valid && (fill_inc == SW'(W)) && (hist_shift == pat_q);
    end

    // Next-state selection; load dominates and discards the current bit.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;
        f_d     = 1'b0;
        if (load) begin
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else if (x_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (match) begin
                f_d     = 1'b1;
                count_d = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);
                if (mode == MODE_NONOVERLAP) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
        end
    end

    dff_n #(.WIDTH(W))  u_pat   (.CLK(CLK), .RESET(RESET), .en(load), .d(pattern), .q(pat_q));
    dff_n #(.WIDTH(W))  u_hist  (.CLK(CLK), .RESET(RESET), .en(1'b1), .d(hist_d),  .q(hist_q));
    dff_n #(.WIDTH(SW)) u_fill  (.CLK(CLK), .RESET(RESET), .en(1'b1), .d(fill_d),  .q(fill_q));
    dff_n #(.WIDTH(CW)) u_count (.CLK(CLK), .RESET(RESET), .en(1'b1), .d(count_d), .q(count_q));
    dff_n #(.WIDTH(1))  u_f     (.CLK(CLK), .RESET(RESET), .en(1'b1), .d(f_d),     .q(F));

    assign S     = fill_q;
    assign count = count_q;

endmodule

// File: tb/tb_pattern_machine.sv
// Scoreboard bench for pattern_machine (W=4, CW=8) against a bit-queue reference model.
module tb_pattern_machine;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = $clog2(W + 1);

    logic          CLK = 1'b0;
    logic          RESET;
    logic          x;
    logic          x_valid;
    logic          mode;
    logic          load;
    logic [W-1:0]  pattern;
    logic          F;
    logic [SW-1:0] S;
    logic [CW-1:0] count;

    typedef struct packed {
        logic          f;
        logic [SW-1:0] s;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: raw received bits, oldest first, at most W kept.
    logic [W-1:0] m_pat;
    logic         m_bits[$];
    int           m_count;
    logic         m_f;

    pattern_machine #(.W(W), .CW(CW)) dut (
        .CLK(CLK), .RESET(RESET), .x(x), .x_valid(x_valid), .mode(mode),
        .load(load), .pattern(pattern), .F(F), .S(S), .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat   = '0;
        m_bits.delete();
        m_count = 0;
        m_f     = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [W-1:0] p, input logic xv,
                              input logic xb, input logic md);
        logic hit;
        if (ld) begin
            m_pat   = p;
            m_bits.delete();
            m_count = 0;
            m_f     = 1'b0;
        end else if (xv) begin
            m_bits.push_back(xb);
            if (m_bits.size() > W) void'(m_bits.pop_front());
            hit = (m_bits.size() == W);
            for (int i = 0; i < W; i++)
                if (hit && m_bits[i] != m_pat[W-1-i]) hit = 1'b0;
            m_f = hit;
            if (hit) begin
                if (m_count < 255) m_count++;
                if (md) m_bits.delete();
            end
        end else begin
            m_f = 1'b0;
        end
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic step(input string tag, input logic ld, input logic [W-1:0] p,
                        input logic xv, input logic xb, input logic md);
        exp_t e;
        load = ld; pattern = p; x_valid = xv; x = xb; mode = md;
        model_edge(ld, p, xv, xb, md);
        e.f = m_f; e.s = SW'(m_bits.size()); e.cnt = CW'(m_count);
        sb.push_back(e);
        @(posedge CLK); #1;
        e = sb.pop_front();
        check({tag, ".F"},     32'(F),     32'(e.f));
        check({tag, ".S"},     32'(S),     32'(e.s));
        check({tag, ".count"}, 32'(count), 32'(e.cnt));
    endtask

    task automatic send_bits(input string tag, input logic [6:0] bits, input int n,
                             input logic md, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, 1'b0, pattern, 1'b1, bits[i], md);
            if (gaps && i > 0) begin
                step({tag, ".gap"}, 1'b0, pattern, 1'b0, 1'b1, md);
                step({tag, ".gap"}, 1'b0, pattern, 1'b0, 1'b0, md);
            end
        end
    endtask

    initial begin
        RESET = 1'b0; x = 1'b0; x_valid = 1'b0; mode = 1'b0; load = 1'b0; pattern = '0;
        model_reset();
        #3;
        check("rst.S", 32'(S), 0);
        check("rst.F", 32'(F), 0);
        check("rst.count", 32'(count), 0);
        // load and x_valid during reset must be ignored
        load = 1'b1; pattern = 4'b1011; x_valid = 1'b1; x = 1'b1;
        @(posedge CLK); #1;
        check("rst_hold.S", 32'(S), 0);
        check("rst_hold.count", 32'(count), 0);
        @(negedge CLK); RESET = 1'b1; load = 1'b0; x_valid = 1'b0;

        // Overlapping stream 1,0,1,1,0,1,1
        step("load1", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        send_bits("ovl", 7'b1011011, 7, 1'b0, 1'b0);
        check("ovl.final_S", 32'(S), 4);
        check("ovl.final_count", 32'(count), 2);

        // Non-overlapping, same stream
        step("load2", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
        send_bits("novl", 7'b1011011, 7, 1'b1, 1'b0);
        check("novl.final_S", 32'(S), 3);
        check("novl.final_count", 32'(count), 1);

        // Gapped stream 1,0,1,1
        step("load3", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        send_bits("gap", 7'b0001011, 4, 1'b0, 1'b1);
        check("gap.final_count", 32'(count), 1);

        // Load with x_valid on the same edge after partial progress
        step("load4", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        send_bits("pre", 7'b0000010, 2, 1'b0, 1'b0);
        check("pre.S", 32'(S), 2);
        step("reload", 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        check("reload.S", 32'(S), 0);
        send_bits("p0110", 7'b0000110, 4, 1'b0, 1'b0);
        check("p0110.count", 32'(count), 1);

        // Asynchronous reset while F is high
        step("load5", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        send_bits("prerst", 7'b0001011, 4, 1'b0, 1'b0);
        check("prerst.F", 32'(F), 1);
        #2 RESET = 1'b0;
        #1;
        model_reset();
        check("async.S", 32'(S), 0);
        check("async.F", 32'(F), 0);
        check("async.count", 32'(count), 0);
        @(negedge CLK); RESET = 1'b1;
        step("post_rst", 1'b0, pattern, 1'b1, 1'b1, 1'b0);
        check("post_rst.S", 32'(S), 1);

        // All-ones saturation
        step("load6", 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 262; i++) step("ones", 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
        check("sat.count", 32'(count), 255);
        check("sat.F", 32'(F), 1);
        step("idle", 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        check("idle.count", 32'(count), 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_machine.md
PATTERN_MACHINE -- requirements
Module: pattern_machine

Interface
REQ-001 Parameter W, default 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter CW, default 8, match-counter width in bits.
REQ-003 Local width SW = clog2(W+1), width of the S progress output.
REQ-004 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 x  input  1  serial data bit.
REQ-007 x_valid  input  1  x is sampled only when high.
REQ-008 mode  input  1  0 = overlapping detection, 1 = non-overlapping detection.
REQ-009 load  input  1  one-cycle strobe that latches the pattern input.
REQ-010 pattern  input  W  target sequence; pattern[W-1] is the first bit expected, pattern[0] the last.
REQ-011 F  output  1  registered one-cycle match pulse.
REQ-012 S  output  SW  current fill level (valid bits held in history, 0..W).
REQ-013 count  output  CW  saturating count of matches since reset or load.

Function
REQ-014 Block SHALL hold registers: pat (W), hist (W), fill (SW), F, count (CW).
REQ-015 On an edge with load=1: pat<=pattern, hist<=0, fill<=0, count<=0, F<=0; x is discarded even if x_valid=1.
REQ-016 On an edge with load=0 and x_valid=1: hist<={hist[W-2:0],x}, newest bit at LSB; fill<=min(fill+1,W).
REQ-017 A match occurs on that edge when the new fill equals W and the new hist equals pat.
REQ-018 On a match, F SHALL be 1 for exactly the following cycle; F is 0 in every other cycle.
REQ-019 Latency: F rises on the same edge that samples the final pattern bit (registered, zero extra cycles).
REQ-020 On a match with mode=0, hist and fill keep their shifted values, so overlapping matches are detected.
REQ-021 On a match with mode=1, hist<=0 and fill<=0 on that edge; the next match needs W fresh bits.
REQ-022 On a match, count<=count+1, saturating at 2^CW-1; it never wraps.
REQ-023 With x_valid=0 and load=0: hist, fill, count hold and F<=0.
REQ-024 mode is sampled on every edge; a change affects only matches detected on or after that edge.
REQ-025 S SHALL equal fill at all times.

Reset
REQ-026 RESET low SHALL immediately, regardless of CLK, force pat=0, hist=0, fill=0, F=0, count=0.
REQ-027 Reset mid-sequence SHALL discard all partial progress; after release the first edge with x_valid=1 gives fill=1.
REQ-028 While RESET is low, load and x_valid SHALL be ignored.

Structure
REQ-029 Shared package pattern_machine_pkg SHALL hold the defaults for W and CW and the constants MODE_OVERLAP=0 and MODE_NONOVERLAP=1.
REQ-030 Every state register SHALL be an instance of sub-module dff_n: a width-parameterised D register with CLK, asynchronous active-low RESET and an enable input.
REQ-031 Next-state and match logic SHALL be combinational in pattern_machine; no latches.

Verification (W=4, CW=8, pattern loaded 4'b1011 unless noted)
REQ-032 Assert RESET low mid-stream -> S=0, F=0 and count=0 immediately, before the next CLK edge.
REQ-033 mode=0, stream 1,0,1,1,0,1,1 with x_valid=1 -> F pulses after bits 4 and 7, S=4 afterwards, count=2.
REQ-034 mode=1, same stream -> F pulses after bit 4 only, S=3 at end, count=1.
REQ-035 Stream 1,0,1,1 with x_valid=0 cycles inserted between bits -> S and count hold during gaps; single F pulse after bit 4.
REQ-036 After S=2, apply load=1 with pattern=4'b0110 and x_valid=1 on the same edge -> S=0, count=0, F=0; stream 0,1,1,0 then gives one F pulse.
REQ-037 mode=0, continuous all-ones stream with pattern=4'b1111 -> F high on every edge from bit 4 onward; count saturates at 255 and stays there.
